bank_address_unmapping: RTL and testbench
=========================================

BANK_ADDRESS_UNMAPPING -- requirements
Module: bank_address_unmapping

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have ports: KD_mode in 1 (0 Kyber, 1 Dilithium); start in 1, one-cycle request; busy out 1; done out 1, one-cycle pulse.
REQ-003 SHALL have bank read ports: rd_en out 1; rd_addr out 7, common to all four banks; bank_dout_0..3 in 12 each, valid exactly one cycle after the rd_en cycle.
REQ-004 SHALL have output stream: out_valid out 1; out_ready in 1; out_lane_en out 4; out_idx_0..3 out 8 each, original coefficient index; out_data_0..3 out 24 each.

Function
REQ-005 SHALL implement FSM IDLE -> SWEEP -> DRAIN -> DONE -> IDLE; start is ignored outside IDLE; KD_mode is sampled in IDLE on start and held for the whole sweep.
REQ-006 SWEEP SHALL issue rd_addr 0..31 (Kyber) or 0..127 (Dilithium) in increasing order, one address per rd_en cycle, and enter DRAIN after the last address is issued.
REQ-007 SHALL capture returned bank words into a 2-entry output buffer; rd_en SHALL assert only when buffered beats plus in-flight reads < 2, so no beat is ever lost or duplicated.
REQ-008 Latency: start sampled at edge k -> rd_en with addr 0 in cycle k+1 -> out_valid high from cycle k+3 when out_ready is held high; full throughput is then 1 beat/cycle.
REQ-009 A beat SHALL transfer on out_valid && out_ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-010 Kyber, address a[4:0], bank b: idx[6:2]=a; idx[1:0]=(b - a[4] - a[3:2] - a[1:0]) mod 4; idx[7]=0; out_data_b={12'd0, bank_dout_b}; out_lane_en=4'b1111.
REQ-011 Dilithium, address a[6:0]: p = XOR of a[6:0]; lane 0 idx={a, p}, lane 1 idx={a, ~p}; out_data_0={bank_dout_2, bank_dout_0}; out_data_1={bank_dout_3, bank_dout_1}; out_lane_en=4'b0011; lanes 2,3 idx/data SHALL be 0.
REQ-012 DRAIN SHALL last until the buffer is empty and no read is in flight; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-013 busy SHALL be 1 in SWEEP, DRAIN and DONE, 0 in IDLE.
REQ-014 start arriving in the DONE cycle SHALL be ignored; start in the IDLE cycle after DONE SHALL begin a new sweep.

Reset
REQ-015 rst SHALL force state IDLE, clear the buffer and the in-flight flag, and zero the address counter.
REQ-016 After reset: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_lane_en=0, all out_idx/out_data=0.
REQ-017 rst asserted mid-sweep SHALL abort it; the bank word returning in the following cycle SHALL be discarded, and no done pulse SHALL occur.

Configuration
REQ-018 Macro BANK_UNMAP_DILITHIUM_EN: when defined, REQ-011 is supported; when undefined, KD_mode SHALL be ignored, every sweep SHALL be Kyber (32 addresses), and the Dilithium datapath SHALL be absent.

Verification
REQ-019 Kyber, rd_addr 5, bank_dout_0..3 = 0xA00, 0xA01, 0xA02, 0xA03 -> out_idx = 22, 23, 20, 21; out_data = 0x000A00 .. 0x000A03; out_lane_en = 4'b1111.
REQ-020 Dilithium, rd_addr 3, dout0=0x111, dout1=0x222, dout2=0x333, dout3=0x444 -> lane 0 idx 6, data 0x333111; lane 1 idx 7, data 0x444222; out_lane_en = 4'b0011.
REQ-021 Kyber sweep with out_ready held at 1 -> out_valid at k+3; exactly 32 beats on consecutive cycles; done pulses once; busy then drops to 0.
REQ-022 Dilithium sweep with out_ready low for 10 cycles starting at beat 40 -> rd_en stalls within 2 beats; all 128 beats delivered in order, with no gap index and no repeat.
REQ-023 rst asserted at beat 15 of a Kyber sweep -> all outputs at reset values the next cycle, no done pulse; a new start then yields 32 beats beginning at idx 0..3 (address 0).
REQ-024 Build without BANK_UNMAP_DILITHIUM_EN, KD_mode=1, start -> 32 Kyber beats, out_lane_en = 4'b1111.

Source files
------------

// File: rtl/bank_address_unmapping.sv
// bank_address_unmapping: sweeps the four coefficient banks in address order and
// streams each bank word back out tagged with its original coefficient index.
// Optional feature macro: BANK_UNMAP_DILITHIUM_EN enables the Dilithium
// (two 24-bit lanes per address) mode selected by KD_mode; without it every
// sweep is a 32-address Kyber sweep and KD_mode is ignored.
module bank_address_unmapping (
  input  logic        clk,
  input  logic        rst,
  input  logic        KD_mode,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [6:0]  rd_addr,
  input  logic [11:0] bank_dout_0,
  input  logic [11:0] bank_dout_1,
  input  logic [11:0] bank_dout_2,
  input  logic [11:0] bank_dout_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_lane_en,
  output logic [7:0]  out_idx_0,
  output logic [7:0]  out_idx_1,
  output logic [7:0]  out_idx_2,
  output logic [7:0]  out_idx_3,
  output logic [23:0] out_data_0,
  output logic [23:0] out_data_1,
  output logic [23:0] out_data_2,
  output logic [23:0] out_data_3
);

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned WORD_W     = 12;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned LANES      = 4;
  localparam int unsigned KYBER_LAST = 31;
  localparam int unsigned DIL_LAST   = 127;

  typedef struct packed {
    logic [LANES-1:0]             lane_en;
    logic [LANES-1:0][IDX_W-1:0]  idx;
    logic [LANES-1:0][DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [ADDR_W-1:0]           inflight_addr_q, inflight_addr_d;
  logic                        inflight_q, inflight_d;
  beat_t                       head_q, head_d, skid_q, skid_d, arr_beat;
  logic                        head_valid_q, head_valid_d;
  logic                        skid_valid_q, skid_valid_d;
  logic                        sweep_dil;
  logic                        pop;
  logic [1:0]                  occ_after;
  logic [ADDR_W-1:0]           last_addr;
  logic [LANES-1:0][WORD_W-1:0] dout;

  assign dout = {bank_dout_3, bank_dout_2, bank_dout_1, bank_dout_0};

`ifdef BANK_UNMAP_DILITHIUM_EN
  logic mode_q, mode_d;

  // Latch the sweep mode when a request is accepted
  always_comb begin
    mode_d = mode_q;
    if (state_q == S_IDLE && start) mode_d = KD_mode;
  end

  // Mode register
  always_ff @(posedge clk) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end

  assign sweep_dil = mode_q;
`else
  logic unused_kd;
  assign unused_kd = ^{KD_mode, inflight_addr_q[ADDR_W-1:5]};
  assign sweep_dil = 1'b0;
`endif

  // Credit check: issue only if the buffer can absorb every outstanding word
  always_comb begin
    pop       = head_valid_q & out_ready;
    occ_after = 2'(head_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(pop);
    last_addr = sweep_dil ? ADDR_W'(DIL_LAST) : ADDR_W'(KYBER_LAST);
    rd_en     = (state_q == S_SWEEP) && (occ_after < 2'd2);
  end

  assign rd_addr = addr_q;

  // Address counter and in-flight read tracking
  always_comb begin
    addr_d          = addr_q;
    inflight_d      = rd_en;
    inflight_addr_d = inflight_addr_q;
    if (state_q == S_IDLE && start) addr_d = '0;
    if (rd_en) begin
      inflight_addr_d = addr_q;
      addr_d          = (addr_q == last_addr) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  // Map the returning bank words back to coefficient indices
  always_comb begin
    arr_beat         = '0;
    arr_beat.lane_en = '1;
    for (int b = 0; b < int'(LANES); b++) begin
      arr_beat.idx[b]  = {1'b0, inflight_addr_q[4:0],
                          2'(b) - {1'b0, inflight_addr_q[4]}
                                - inflight_addr_q[3:2] - inflight_addr_q[1:0]};
      arr_beat.data[b] = {{(DATA_W-WORD_W){1'b0}}, dout[b]};
    end
`ifdef BANK_UNMAP_DILITHIUM_EN
    if (sweep_dil) begin
      arr_beat         = '0;
      arr_beat.lane_en = 4'b0011;
      arr_beat.idx[0]  = {inflight_addr_q, ^inflight_addr_q};
      arr_beat.idx[1]  = {inflight_addr_q, ~(^inflight_addr_q)};
      arr_beat.data[0] = {dout[2], dout[0]};
      arr_beat.data[1] = {dout[3], dout[1]};
    end
`endif
  end

  // Two-entry output buffer: head drives the stream, skid catches a stalled arrival
  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!head_valid_q || pop) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = inflight_q;
        if (inflight_q) skid_d = arr_beat;
      end else begin
        head_valid_d = inflight_q;
        if (inflight_q) head_d = arr_beat;
      end
    end else if (inflight_q) begin
      skid_d       = arr_beat;
      skid_valid_d = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SWEEP;
      S_SWEEP: if (rd_en && addr_q == last_addr) state_d = S_DRAIN;
      S_DRAIN: if (!head_valid_q && !skid_valid_q && !inflight_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; reset drops the buffer and any word still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      head_q          <= '0;
      head_valid_q    <= 1'b0;
      skid_q          <= '0;
      skid_valid_q    <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      head_q          <= head_d;
      head_valid_q    <= head_valid_d;
      skid_q          <= skid_d;
      skid_valid_q    <= skid_valid_d;
    end
  end

  assign out_valid   = head_valid_q;
  assign out_lane_en = head_q.lane_en;
  assign out_idx_0   = head_q.idx[0];
  assign out_idx_1   = head_q.idx[1];
  assign out_idx_2   = head_q.idx[2];
  assign out_idx_3   = head_q.idx[3];
  assign out_data_0  = head_q.data[0];
  assign out_data_1  = head_q.data[1];
  assign out_data_2  = head_q.data[2];
  assign out_data_3  = head_q.data[3];

endmodule

// File: tb/tb_bank_address_unmapping.sv
// Bench for bank_address_unmapping: bank memory model, expected-beat queue
// built from the index-unmapping rules, and a per-cycle stream checker.
module tb_bank_address_unmapping;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, KD_mode = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic        busy, done, rd_en, out_valid;
  logic [6:0]  rd_addr;
  logic [11:0] bd0, bd1, bd2, bd3;
  logic [3:0]  out_lane_en;
  logic [7:0]  out_idx_0, out_idx_1, out_idx_2, out_idx_3;
  logic [23:0] out_data_0, out_data_1, out_data_2, out_data_3;

  bank_address_unmapping dut (
    .clk(clk), .rst(rst), .KD_mode(KD_mode), .start(start),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .bank_dout_0(bd0), .bank_dout_1(bd1), .bank_dout_2(bd2), .bank_dout_3(bd3),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
    .out_idx_0(out_idx_0), .out_idx_1(out_idx_1), .out_idx_2(out_idx_2), .out_idx_3(out_idx_3),
    .out_data_0(out_data_0), .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3)
  );

  logic [11:0]  mem [4][128];
  int           cmp_total = 0, cmp_bad = 0;
  int           cyc = 0, rdy_mode = 0, rx_count = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0;
  bit           mon_en = 1'b0, hold_prev = 1'b0;
  logic [131:0] prev_beat;
  logic [131:0] expq[$];
  logic [131:0] rx[$];

  localparam logic [131:0] K5 = {4'hF, 8'd21, 8'd20, 8'd23, 8'd22,
                                 24'h000A03, 24'h000A02, 24'h000A01, 24'h000A00};
  localparam logic [131:0] D3 = {4'h3, 8'd0, 8'd0, 8'd7, 8'd6,
                                 24'd0, 24'd0, 24'h444222, 24'h333111};

  always @(posedge clk) cyc <= cyc + 1;

  // Bank memories: word valid exactly one cycle after rd_en, junk otherwise
  always @(posedge clk) begin
    if (rd_en) begin
      bd0 <= mem[0][rd_addr]; bd1 <= mem[1][rd_addr];
      bd2 <= mem[2][rd_addr]; bd3 <= mem[3][rd_addr];
    end else begin
      bd0 <= 12'($urandom); bd1 <= 12'($urandom);
      bd2 <= 12'($urandom); bd3 <= 12'($urandom);
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    cmp_total++;
    if (act !== exp) begin
      cmp_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [131:0] dut_beat();
    return {out_lane_en, out_idx_3, out_idx_2, out_idx_1, out_idx_0,
            out_data_3, out_data_2, out_data_1, out_data_0};
  endfunction

  function automatic logic [131:0] rx_at(input int i);
    if (i < rx.size()) return rx[i];
    return 'x;
  endfunction

  // Expected beat for address a, straight from the unmapping rules
  function automatic logic [131:0] model_beat(input int a, input bit dil);
    logic [7:0]  ix [4];
    logic [23:0] dt [4];
    logic [3:0]  le;
    int          lo, p;
    for (int b = 0; b < 4; b++) begin ix[b] = '0; dt[b] = '0; end
    if (!dil) begin
      le = 4'hF;
      for (int b = 0; b < 4; b++) begin
        lo    = ((b - ((a >> 4) & 1) - ((a >> 2) & 3) - (a & 3)) % 4 + 4) % 4;
        ix[b] = 8'(a * 4 + lo);
        dt[b] = 24'(mem[b][a]);
      end
    end else begin
      le    = 4'h3;
      p     = $countones(7'(a)) & 1;
      ix[0] = 8'(2 * a + p);
      ix[1] = 8'(2 * a + 1 - p);
      dt[0] = {mem[2][a], mem[0][a]};
      dt[1] = {mem[3][a], mem[1][a]};
    end
    return {le, ix[3], ix[2], ix[1], ix[0], dt[3], dt[2], dt[1], dt[0]};
  endfunction

  // Stream checker: every transferred beat against the queue, holds must be stable
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en) begin
      if (hold_prev) begin
        check("hold_valid", 132'(out_valid), 132'(1));
        check("hold_beat", dut_beat(), prev_beat);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          cmp_total++; cmp_bad++;
          $display("FAIL extra_beat: got %0h expected no beat", dut_beat());
        end else begin
          check($sformatf("beat%0d", rx_count), dut_beat(), expq.pop_front());
        end
        rx.push_back(dut_beat());
        if (rx_count == 0) first_cyc = cyc;
        last_cyc = cyc;
        rx_count++;
      end
      hold_prev = out_valid && !out_ready;
      prev_beat = dut_beat();
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic reset_outputs_check(input string tag);
    check({tag, "_busy"}, 132'(busy), 132'(0));
    check({tag, "_done"}, 132'(done), 132'(0));
    check({tag, "_rd_en"}, 132'(rd_en), 132'(0));
    check({tag, "_rd_addr"}, 132'(rd_addr), 132'(0));
    check({tag, "_out_valid"}, 132'(out_valid), 132'(0));
    check({tag, "_payload"}, dut_beat(), 132'(0));
  endtask

  task automatic fill_mem();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 128; a++) mem[b][a] = 12'($urandom);
  endtask

  task automatic start_sweep(input bit mode, input bit rnd, input bit chk_lat);
    bit eff;
`ifdef BANK_UNMAP_DILITHIUM_EN
    eff = mode;
`else
    eff = 1'b0;
`endif
    expq.delete();
    rx.delete();
    for (int a = 0; a < (eff ? 128 : 32); a++) expq.push_back(model_beat(a, eff));
    rx_count = 0;
    rdy_mode = rnd ? 1 : 0;
    mon_en   = 1'b1;
    @(posedge clk); #1 start = 1'b1; KD_mode = mode;
    @(posedge clk); #1 start = 1'b0; KD_mode = ~mode;
    if (chk_lat) begin
      @(negedge clk);
      check("lat_rd_first", 132'({rd_en, rd_addr}), 132'({1'b1, 7'd0}));
      check("lat_busy", 132'(busy), 132'(1));
      @(negedge clk);
      check("lat_valid_early", 132'(out_valid), 132'(0));
      @(negedge clk);
      check("lat_valid_k3", 132'(out_valid), 132'(1));
    end
  endtask

  task automatic finish_sweep(input int stall_at, input bit start_in_done, input int n_exp);
    bit got = 1'b0, stalled = 1'b0;
    int stall_cyc = 0, rd_in_stall = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (stall_at >= 0 && !stalled && rx_count >= stall_at) begin
        stalled  = 1'b1;
        rdy_mode = 2;
      end else if (stalled && stall_cyc < 10 && !out_ready) begin
        stall_cyc++;
        if (rd_en) rd_in_stall++;
        if (stall_cyc == 10) rdy_mode = 0;
      end
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", 132'(got), 132'(1));
    if (got) begin
      if (start_in_done) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("after_done_busy", 132'({busy, done}), 132'(0));
      @(negedge clk);
      check("start_in_done_ignored", 132'(busy), 132'(0));
    end
    rdy_mode = 0;
    check("beat_count", 132'(rx_count), 132'(n_exp));
    check("queue_empty", 132'(expq.size()), 132'(0));
    if (stall_at >= 0) begin
      check("stall_window", 132'(stall_cyc), 132'(10));
      check("stall_rd_en_bound", 132'(rd_in_stall > 2), 132'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc;
    logic [131:0] b0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs_check("rst");
    @(posedge clk); #1 rst = 1'b0;

    // Kyber, always ready: latency, back-to-back beats, pinned address 5
    fill_mem();
    mem[0][5] = 12'hA00; mem[1][5] = 12'hA01; mem[2][5] = 12'hA02; mem[3][5] = 12'hA03;
    check("model_pin_k5", model_beat(5, 1'b0), K5);
    start_sweep(1'b0, 1'b0, 1'b1);
    finish_sweep(-1, 1'b1, 32);
    check("consecutive", 132'(last_cyc - first_cyc), 132'(31));
    check("rx_addr5", rx_at(5), K5);
    check("done_pulses", 132'(done_cnt), 132'(1));

    // Kyber, random backpressure plus a long stall
    fill_mem();
    start_sweep(1'b0, 1'b1, 1'b0);
    finish_sweep(20, 1'b0, 32);

    // Abort with reset at beat 15, then a clean restart
    fill_mem();
    start_sweep(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 500 && rx_count < 15; c++) @(negedge clk);
    check("abort_reached", 132'(rx_count >= 15), 132'(1));
    mon_en = 1'b0;
    dc = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    reset_outputs_check("abort");
    repeat (40) @(negedge clk);
    check("abort_no_done", 132'(done_cnt), 132'(dc));
    start_sweep(1'b0, 1'b0, 1'b1);
    finish_sweep(-1, 1'b0, 32);

    // KD_mode = 1: Dilithium when built in, otherwise plain Kyber
    fill_mem();
`ifdef BANK_UNMAP_DILITHIUM_EN
    mem[0][3] = 12'h111; mem[1][3] = 12'h222; mem[2][3] = 12'h333; mem[3][3] = 12'h444;
    check("model_pin_d3", model_beat(3, 1'b1), D3);
    start_sweep(1'b1, 1'b0, 1'b1);
    finish_sweep(40, 1'b0, 128);
    check("rx_addr3_dil", rx_at(3), D3);
`else
    start_sweep(1'b1, 1'b0, 1'b1);
    finish_sweep(-1, 1'b0, 32);
    b0 = rx_at(0);
    check("kd_ignored_lane_en", 132'(b0[131:128]), 132'(4'hF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_total, cmp_bad);
    $finish;
  end

endmodule
